// File: rtl/isa_pkg.sv
// ISA constants, instruction-word layout and loader FSM state shared by encoder and decoder.
package isa_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned OPC_W  = 5;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned IMM_W  = 17;

    // Bit positions (LSB) of each field inside the 32-bit instruction word
    localparam int unsigned OPC_LSB   = 27;
    localparam int unsigned RD_LSB    = 22;
    localparam int unsigned RS_LSB    = 17;
    localparam int unsigned RT_LSB    = 12;
    localparam int unsigned SHAMT_LSB = 7;
    localparam int unsigned ALUOP_LSB = 2;
    localparam int unsigned IMM_LSB   = 0;

    localparam logic [OPC_W-1:0] OP_RTYPE = 5'b00000;
    localparam logic [OPC_W-1:0] OP_ADDI  = 5'b00101;
    localparam logic [OPC_W-1:0] OP_SW    = 5'b00111;
    localparam logic [OPC_W-1:0] OP_LW    = 5'b01000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } wr_state_t;

    // True for the opcodes the control decoder understands
    function automatic logic is_supported_op(input logic [OPC_W-1:0] op);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_RTYPE, OP_ADDI, OP_SW, OP_LW: ok = 1'b1;
            default:                         ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/instr_stream_writer_if.sv
// Field-bundle stream in, instruction-memory write bus out.
interface instr_stream_writer_if #(
    parameter int unsigned ADDR_W = 12
);
    import isa_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [OPC_W-1:0]     in_opcode;
    logic [REG_W-1:0]     in_rd;
    logic [REG_W-1:0]     in_rs;
    logic [REG_W-1:0]     in_rt;
    logic [REG_W-1:0]     in_shamt;
    logic [REG_W-1:0]     in_aluop;
    logic [IMM_W-1:0]     in_imm;
    logic                 in_last;
    logic                 imem_wren;
    logic [ADDR_W-1:0]    imem_addr;
    logic [WORD_W-1:0]    imem_data;

    modport master (
        output in_valid, in_opcode, in_rd, in_rs, in_rt, in_shamt, in_aluop, in_imm, in_last,
        input  in_ready, imem_wren, imem_addr, imem_data
    );

    modport slave (
        input  in_valid, in_opcode, in_rd, in_rs, in_rt, in_shamt, in_aluop, in_imm, in_last,
        output in_ready, imem_wren, imem_addr, imem_data
    );

endinterface

// File: rtl/instr_pack.sv
// Combinational packer from decoded fields to the 32-bit ISA word.
module instr_pack
    import isa_pkg::*;
(
    input  logic [OPC_W-1:0]  opcode,
    input  logic [REG_W-1:0]  rd,
    input  logic [REG_W-1:0]  rs,
    input  logic [REG_W-1:0]  rt,
    input  logic [REG_W-1:0]  shamt,
    input  logic [REG_W-1:0]  aluop,
    input  logic [IMM_W-1:0]  imm,
    output logic [WORD_W-1:0] word_c,
    output logic              is_supported
);

    // R-type carries rt/shamt/aluop with two zero LSBs; I-types carry the 17-bit immediate
    always_comb begin
        word_c                        = '0;
        is_supported                  = is_supported_op(opcode);
        word_c[OPC_LSB +: OPC_W]      = opcode;
        word_c[RD_LSB  +: REG_W]      = rd;
        word_c[RS_LSB  +: REG_W]      = rs;
        if (opcode == OP_RTYPE) begin
            word_c[RT_LSB    +: REG_W] = rt;
            word_c[SHAMT_LSB +: REG_W] = shamt;
            word_c[ALUOP_LSB +: REG_W] = aluop;
        end else begin
            word_c[IMM_LSB +: IMM_W]   = imm;
        end
    end

endmodule

// File: rtl/instr_stream_writer.sv
// Accepts decoded instruction bundles and writes packed words to consecutive imem addresses.
module instr_stream_writer
    import isa_pkg::*;
#(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned BASE   = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    instr_stream_writer_if.slave  bus,
    output logic                  busy,
    output logic                  done,
    output logic                  err_opcode,
    output logic                  overflow,
    output logic [ADDR_W:0]       word_count
);

    localparam int unsigned       CNT_W     = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;
    localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BASE);

    wr_state_t          state;
    logic [ADDR_W-1:0]  addr_ptr;
    logic               last_q;
    logic               in_ready_q;
    logic               wren_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [WORD_W-1:0]  data_q;
    logic [WORD_W-1:0]  word_c;
    logic               supported_c;

    instr_pack u_pack (
        .opcode       (bus.in_opcode),
        .rd           (bus.in_rd),
        .rs           (bus.in_rs),
        .rt           (bus.in_rt),
        .shamt        (bus.in_shamt),
        .aluop        (bus.in_aluop),
        .imm          (bus.in_imm),
        .word_c       (word_c),
        .is_supported (supported_c)
    );

    assign bus.in_ready  = in_ready_q;
    assign bus.imem_wren = wren_q;
    assign bus.imem_addr = addr_q;
    assign bus.imem_data = data_q;

    // Session FSM; every output is registered from the state being entered
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            addr_ptr   <= '0;
            last_q     <= 1'b0;
            in_ready_q <= 1'b0;
            wren_q     <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err_opcode <= 1'b0;
            overflow   <= 1'b0;
            word_count <= '0;
        end else begin
            wren_q <= 1'b0;
            done   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_LOAD;
                        in_ready_q <= 1'b1;
                        busy       <= 1'b1;
                        addr_ptr   <= BASE_ADDR;
                        word_count <= '0;
                        err_opcode <= 1'b0;
                        overflow   <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    // in_ready is high throughout LOAD, so in_valid alone marks a transfer
                    if (bus.in_valid) begin
                        if (supported_c) begin
                            state      <= ST_WRITE;
                            in_ready_q <= 1'b0;
                            wren_q     <= 1'b1;
                            addr_q     <= addr_ptr;
                            data_q     <= word_c;
                            last_q     <= bus.in_last;
                        end else begin
                            err_opcode <= 1'b1;
                            if (bus.in_last) begin
                                state      <= ST_DONE;
                                in_ready_q <= 1'b0;
                                busy       <= 1'b0;
                                done       <= 1'b1;
                            end
                        end
                    end
                end
                ST_WRITE: begin
                    word_count <= word_count + CNT_W'(1);
                    // Pointer saturates at the top of the address space instead of wrapping
                    if (addr_ptr != ADDR_MAX) begin
                        addr_ptr <= addr_ptr + ADDR_W'(1);
                    end
                    if (last_q || (addr_ptr == ADDR_MAX)) begin
                        state      <= ST_DONE;
                        in_ready_q <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        if (addr_ptr == ADDR_MAX) begin
                            overflow <= 1'b1;
                        end
                    end else begin
                        state      <= ST_LOAD;
                        in_ready_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_stream_writer.sv
// Randomized bench for instr_stream_writer against a session-level reference model.
module tb_instr_stream_writer;

    localparam int unsigned AW     = 3;
    localparam int unsigned BASE   = 4;
    localparam int          TOPADR = (1 << AW) - 1;

    typedef struct {
        logic [4:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  shamt;
        logic [4:0]  aluop;
        logic [16:0] imm;
        logic        last;
    } bundle_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        busy;
    logic        done;
    logic        err_opcode;
    logic        overflow;
    logic [AW:0] word_count;

    int checks   = 0;
    int failures = 0;
    int wr_seen  = 0;
    int wr_exp   = 0;

    bundle_t q[$];

    instr_stream_writer_if #(.ADDR_W(AW)) bus ();

    instr_stream_writer #(.ADDR_W(AW), .BASE(BASE)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .err_opcode (err_opcode),
        .overflow   (overflow),
        .word_count (word_count)
    );

    always #5 clock = ~clock;

    // Count every cycle the write strobe is seen high
    always @(negedge clock) begin
        if (bus.imem_wren === 1'b1) wr_seen++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    function automatic bit supported(input logic [4:0] op);
        return (op == 5'd0) || (op == 5'd5) || (op == 5'd7) || (op == 5'd8);
    endfunction

    function automatic logic [31:0] ref_word(input bundle_t b);
        logic [31:0] w;
        w = (32'(b.op) << 27) | (32'(b.rd) << 22) | (32'(b.rs) << 17);
        if (b.op == 5'd0) w = w | (32'(b.rt) << 12) | (32'(b.shamt) << 7) | (32'(b.aluop) << 2);
        else              w = w | 32'(b.imm);
        return w;
    endfunction

    function automatic bundle_t mk(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs,
                                   input logic [4:0] rt, input logic [4:0] aluop,
                                   input logic [16:0] imm, input logic last);
        bundle_t b;
        b.op = op; b.rd = rd; b.rs = rs; b.rt = rt; b.shamt = 5'd0; b.aluop = aluop;
        b.imm = imm; b.last = last;
        return b;
    endfunction

    function automatic bundle_t rnd(input logic [4:0] op, input logic last);
        bundle_t b;
        b.op = op; b.rd = 5'($urandom); b.rs = 5'($urandom); b.rt = 5'($urandom);
        b.shamt = 5'($urandom); b.aluop = 5'($urandom); b.imm = 17'($urandom); b.last = last;
        return b;
    endfunction

    task automatic drive(input bundle_t b);
        bus.in_valid  = 1'b1;
        bus.in_opcode = b.op;
        bus.in_rd     = b.rd;
        bus.in_rs     = b.rs;
        bus.in_rt     = b.rt;
        bus.in_shamt  = b.shamt;
        bus.in_aluop  = b.aluop;
        bus.in_imm    = b.imm;
        bus.in_last   = b.last;
    endtask

    // Plays queue q as one session; the model tracks address, count and flags from the rules
    task automatic run_session();
        int addr;
        int cnt;
        bit err;
        bit ovf;
        bit ended;
        int budget;
        addr = BASE; cnt = 0; err = 0; ovf = 0; ended = 0;
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
        check_eq("start_ready", 32'(bus.in_ready), 32'd1);
        check_eq("start_busy", 32'(busy), 32'd1);
        check_eq("start_count", 32'(word_count), 32'd0);
        check_eq("start_err", 32'(err_opcode), 32'd0);
        check_eq("start_ovf", 32'(overflow), 32'd0);
        foreach (q[i]) begin
            if (ended) begin
                // Session already over: this bundle must never be taken
                drive(q[i]);
                repeat (4) begin
                    @(negedge clock);
                    check_eq("late_ready", 32'(bus.in_ready), 32'd0);
                end
                bus.in_valid = 1'b0;
                break;
            end
            repeat ($urandom_range(0, 2)) begin
                @(negedge clock);
                check_eq("gap_ready", 32'(bus.in_ready), 32'd1);
            end
            drive(q[i]);
            budget = 0;
            while (bus.in_ready !== 1'b1 && budget < 8) begin
                @(negedge clock);
                budget++;
            end
            check_eq("ready_before_xfer", 32'(bus.in_ready), 32'd1);
            @(negedge clock);
            bus.in_valid = 1'b0;
            if (supported(q[i].op)) begin
                wr_exp++;
                check_eq("wr_en", 32'(bus.imem_wren), 32'd1);
                check_eq("wr_addr", 32'(bus.imem_addr), 32'(addr));
                check_eq("wr_data", bus.imem_data, ref_word(q[i]));
                check_eq("wr_ready", 32'(bus.in_ready), 32'd0);
                ended = q[i].last || (addr == TOPADR);
                if (addr == TOPADR) ovf = 1;
                else                addr++;
                cnt++;
                @(negedge clock);
                check_eq("post_wr_en", 32'(bus.imem_wren), 32'd0);
                check_eq("post_wr_count", 32'(word_count), 32'(cnt));
                check_eq("post_wr_done", 32'(done), 32'(ended));
                check_eq("post_wr_ready", 32'(bus.in_ready), 32'(!ended));
            end else begin
                err = 1;
                ended = q[i].last;
                check_eq("rej_wr_en", 32'(bus.imem_wren), 32'd0);
                check_eq("rej_err", 32'(err_opcode), 32'd1);
                check_eq("rej_done", 32'(done), 32'(ended));
                check_eq("rej_ready", 32'(bus.in_ready), 32'(!ended));
            end
        end
        @(negedge clock);
        check_eq("end_done", 32'(done), 32'd0);
        check_eq("end_busy", 32'(busy), 32'd0);
        check_eq("end_ready", 32'(bus.in_ready), 32'd0);
        // Ignored stimulus while idle; results must hold
        drive(rnd(5'd5, 1'b0));
        repeat (2) @(negedge clock);
        bus.in_valid = 1'b0;
        check_eq("idle_count", 32'(word_count), 32'(cnt));
        check_eq("idle_err", 32'(err_opcode), 32'(err));
        check_eq("idle_ovf", 32'(overflow), 32'(ovf));
        check_eq("write_total", 32'(wr_seen), 32'(wr_exp));
        q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bundle_t b;
        reset = 1'b1;
        start = 1'b0;
        drive(rnd(5'd0, 1'b0));
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clock);
        check_eq("rst_ready", 32'(bus.in_ready), 32'd0);
        check_eq("rst_wren", 32'(bus.imem_wren), 32'd0);
        check_eq("rst_addr", 32'(bus.imem_addr), 32'd0);
        check_eq("rst_data", bus.imem_data, 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_flags", 32'({err_opcode, overflow}), 32'd0);
        check_eq("rst_count", 32'(word_count), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // addi $1,$0,5 as the only bundle
        q.push_back(mk(5'd5, 5'd1, 5'd0, 5'd0, 5'd0, 17'd5, 1'b1));
        run_session();
        // add then sub $3,$1,$2
        q.push_back(mk(5'd0, 5'd3, 5'd1, 5'd2, 5'd0, 17'd0, 1'b0));
        q.push_back(mk(5'd0, 5'd3, 5'd1, 5'd2, 5'd1, 17'd0, 1'b1));
        run_session();
        // sw $5,8($2)
        q.push_back(mk(5'd7, 5'd5, 5'd2, 5'd0, 5'd0, 17'd8, 1'b1));
        run_session();
        // unsupported opcode between two addi bundles
        q.push_back(rnd(5'd5, 1'b0));
        q.push_back(rnd(5'd3, 1'b0));
        q.push_back(rnd(5'd5, 1'b1));
        run_session();
        // more bundles than free addresses, no last marker
        for (int i = 0; i < 5; i++) q.push_back(rnd(5'd5, 1'b0));
        run_session();
        // rejected bundle carrying last
        q.push_back(rnd(5'd3, 1'b1));
        run_session();

        // Random sessions
        for (int s = 0; s < 30; s++) begin
            int n;
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                logic [4:0] op;
                case ($urandom_range(0, 9))
                    0, 1:    op = 5'd0;
                    2, 3:    op = 5'd5;
                    4, 5:    op = 5'd7;
                    6, 7:    op = 5'd8;
                    default: op = 5'($urandom);
                endcase
                q.push_back(rnd(op, (i == n - 1) ? 1'b1 : 1'b0));
            end
            run_session();
        end

        // Reset during a write drops it; start with in_valid already high stays clean
        b = rnd(5'd8, 1'b1);
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
        drive(b);
        @(negedge clock);
        bus.in_valid = 1'b0;
        check_eq("pre_rst_wren", 32'(bus.imem_wren), 32'd1);
        wr_exp++;
        #2 reset = 1'b1;
        #1;
        check_eq("midrst_wren", 32'(bus.imem_wren), 32'd0);
        check_eq("midrst_ready", 32'(bus.in_ready), 32'd0);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        drive(b);
        @(negedge clock); reset = 1'b0;
        @(negedge clock);
        check_eq("idle_valid_wren", 32'(bus.imem_wren), 32'd0);
        check_eq("idle_valid_ready", 32'(bus.in_ready), 32'd0);
        start = 1'b1;
        @(negedge clock); start = 1'b0;
        check_eq("restart_wren", 32'(bus.imem_wren), 32'd0);
        check_eq("restart_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clock);
        bus.in_valid = 1'b0;
        wr_exp++;
        check_eq("restart_wr_en", 32'(bus.imem_wren), 32'd1);
        check_eq("restart_wr_addr", 32'(bus.imem_addr), 32'(BASE));
        check_eq("restart_wr_data", bus.imem_data, ref_word(b));
        @(negedge clock);
        check_eq("restart_done", 32'(done), 32'd1);
        check_eq("restart_count", 32'(word_count), 32'd1);
        @(negedge clock);
        check_eq("restart_idle", 32'(done), 32'd0);
        check_eq("final_write_total", 32'(wr_seen), 32'(wr_exp));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_stream_writer.md
# instr_stream_writer

Sequential instruction encoder and loader for the single-cycle processor. It accepts decoded instruction fields over a valid/ready stream and packs each one into the 32-bit ISA word format. It then writes the packed words into consecutive instruction-memory locations. It is the producer side of the opcode/control path: the control decoder reads `imem[31:27]`, and this block writes them. Only the four opcodes the control decoder supports are encoded: R-type `00000`, addi `00101`, sw `00111` and lw `01000`. Any other opcode is rejected and flagged.

## Interface
Parameters:
- `ADDR_W`, default 12: instruction-memory address width.
- `BASE`, default 0: first address written after `start`.

Ports (one clock; reset is asynchronous and active-high):
- `clock` input 1: sole clock, rising edge.
- `reset` input 1: asynchronous, active-high; returns the block to IDLE.
- `start` input 1: single-cycle pulse that begins a load session.
- `in_valid` input 1: field bundle valid.
- `in_ready` output 1: block can accept a bundle.
- `in_opcode` input 5: instruction opcode.
- `in_rd` input 5: destination register.
- `in_rs` input 5: source register.
- `in_rt` input 5: second source register (R-type only).
- `in_shamt` input 5: shift amount (R-type only).
- `in_aluop` input 5: ALU op (R-type only).
- `in_imm` input 17: immediate (I-type only).
- `in_last` input 1: marks the final bundle of the session.
- `imem_wren` output 1: instruction-memory write strobe.
- `imem_addr` output ADDR_W: write address.
- `imem_data` output 32: packed instruction word.
- `busy` output 1: high in LOAD and WRITE.
- `done` output 1: one-cycle pulse when the session ends.
- `err_opcode` output 1: sticky flag for an unsupported opcode.
- `overflow` output 1: sticky flag set when the address space is exhausted.
- `word_count` output ADDR_W+1: number of words written this session.

## Operation
Packing rules:
- R-type (`00000`): `{opcode, rd, rs, rt, shamt, aluop, 2'b00}`.
- I-type (`00101`, `00111`, `01000`): `{opcode, rd, rs, imm[16:0]}`.

States:
- **IDLE:** `in_ready=0`.
  - `start` → LOAD.
  - On entry to LOAD: `addr_ptr=BASE`; `word_count`, `err_opcode` and `overflow` are cleared.
- **LOAD:** `in_ready=1`.
  - A transfer occurs when `in_valid && in_ready`.
  - Supported opcode: the word is registered and the state goes to WRITE.
  - Unsupported opcode: `err_opcode` is set, nothing is written and `addr_ptr` is unchanged. The state stays in LOAD, or goes to DONE if `in_last` was set.
- **WRITE:** `in_ready=0`, `imem_wren=1`, `imem_addr=addr_ptr`, `imem_data=` the packed word.
  - On exit, `addr_ptr` and `word_count` increment.
  - If the bundle had `in_last` set, or `addr_ptr` was `2^ADDR_W-1` → DONE. The address-limit case also sets `overflow`; the pointer does not wrap.
  - Otherwise → LOAD.
- **DONE:** `done=1` for one cycle → IDLE.

Other rules:
- `start` outside IDLE is ignored.
- `in_valid` outside LOAD is ignored; no transfer occurs.
- `word_count` and both error flags hold their values through IDLE until the next `start`.

## Timing
- Every output is a registered output.
- Reset values: `in_ready=0`, `imem_wren=0`, `imem_addr=0`, `imem_data=0`, `busy=0`, `done=0`, `err_opcode=0`, `overflow=0`, `word_count=0`, state IDLE.
- `start` at cycle t → `in_ready=1` at t+1.
- Transfer at cycle t → `imem_wren` high for exactly one cycle at t+1, with address and data valid in that same cycle.
  - `in_ready` is 0 at t+1 and 1 again at t+2.
  - Throughput is therefore one word per 2 cycles.
- Last write at t+1 → `done` at t+2 → IDLE at t+3.
- Rejected `in_last` transfer at t → `done` at t+1.
- `reset` asserted mid-session: all outputs clear immediately. An in-flight write is dropped, even if `imem_wren` was high.

## Structure
Shared package `isa_pkg`, also used by the control decoder:
- Opcode constants `OP_RTYPE`, `OP_ADDI`, `OP_SW`, `OP_LW`.
- Field-width constants and bit positions of the instruction word.
- The FSM state enum.

Sub-module `instr_pack`:
- Combinational field-to-word packer.
- Has an `is_supported` output.
- Can be reused by the testbench as a golden model.

## Test plan
- addi: `start`, one bundle with opcode `00101`, rd=1, rs=0, imm=5, `in_last=1` → one write of `0x28400005` at addr 0; `done` one cycle later; `word_count=1`.
- R-type stream: add `$3,$1,$2` (aluop 0) then sub `$3,$1,$2` (aluop 1, `in_last`) → `0x00C22000` at addr 0 and `0x00C22004` at addr 1; second `in_ready` rise two cycles after the first transfer.
- sw `$5,8($2)` with `BASE=16` → `0x39440008` at addr 16.
- Opcode `00011` mid-stream, between two valid addi bundles → `err_opcode=1`; the valid words land at consecutive addresses with no gap; `word_count=2`.
- `ADDR_W=2`, five bundles and no `in_last` → writes to addresses 0..3, then `overflow=1` and `done`; the fifth bundle is never accepted.
- `reset` asserted during WRITE → `imem_wren=0` immediately; after release, state is IDLE and a `start` with `in_valid` held high causes no spurious write before `in_ready`.
